// File: rtl/rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl
//
// Powers NUM_DOM clock/reset domains up and down, one command at a time.
// Each domain sits behind a reset synchronizer with an integrated clock gate.
// Power-up releases reset first, waits for the synchronizer to drain, then
// enables the clock. Power-down gates the clock first, waits for it to
// settle, then asserts reset. The clock and reset edges therefore never race.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   req_valid_i   command valid
//   req_ready_o   command accepted when valid & ready (high only in IDLE)
//   req_dom_i     target domain index
//   req_on_i      1 = power up, 0 = power down
//   done_o        one-cycle pulse when a command finishes
//   done_err_o    qualifies done_o; 1 = domain index out of range
//   dom_rst_o     per-domain reset request, active high
//   dom_clk_en_o  per-domain functional clock enable
//   dom_on_o      per-domain status, 1 = fully up
//   busy_o        a command is in progress
// ---------------------------------------------------------------------------
module rst_seq_ctrl #(
   parameter int NUM_DOM  = 4,
   parameter int DOM_W    = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1,
   parameter int RST_WAIT = 6,
   parameter int CLK_WAIT = 2,
   parameter int CNT_W    = $clog2(((RST_WAIT > CLK_WAIT) ? RST_WAIT : CLK_WAIT) + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [DOM_W-1:0]   req_dom_i,
   input  logic               req_on_i,
   output logic               done_o,
   output logic               done_err_o,
   output logic [NUM_DOM-1:0] dom_rst_o,
   output logic [NUM_DOM-1:0] dom_clk_en_o,
   output logic [NUM_DOM-1:0] dom_on_o,
   output logic               busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      RST_REL,
      CLK_SETTLE,
      CLK_OFF,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DOM_W-1:0]   dom_q, dom_d;
   logic [NUM_DOM-1:0] rst_q, rst_d;
   logic [NUM_DOM-1:0] clk_en_q, clk_en_d;
   logic [NUM_DOM-1:0] on_q, on_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [NUM_DOM-1:0] req_sel;
   logic [NUM_DOM-1:0] lat_sel;
   logic               req_bad;
   logic               req_is_on;

   // One-hot decode of the incoming and latched domain index. Decoding with
   // a compare loop keeps out-of-range indices from ever touching a bit.
   always_comb begin
      req_sel = '0;
      lat_sel = '0;
      for (int i = 0; i < NUM_DOM; i++) begin
         req_sel[i] = (req_dom_i == DOM_W'(i));
         lat_sel[i] = (dom_q == DOM_W'(i));
      end
      req_bad   = (int'(req_dom_i) >= NUM_DOM);
      req_is_on = |(on_q & req_sel);
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and next-register logic. Only bits of the latched domain are
   // ever modified; every other domain holds its value by default. The wait
   // counter is loaded with a nonzero value and the phase ends on the edge
   // where it reads 1, so it never wraps.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dom_d    = dom_q;
      rst_d    = rst_q;
      clk_en_d = clk_en_q;
      on_d     = on_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               dom_d = req_dom_i;
               if (req_bad) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (req_on_i == req_is_on) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (req_on_i) begin
                  rst_d   = rst_q & ~req_sel;
                  cnt_d   = CNT_W'(RST_WAIT);
                  state_d = RST_REL;
               end else begin
                  clk_en_d = clk_en_q & ~req_sel;
                  on_d     = on_q & ~req_sel;
                  cnt_d    = CNT_W'(CLK_WAIT);
                  state_d  = CLK_OFF;
               end
            end
         end
         RST_REL: begin
            if (cnt_q == CNT_W'(1)) begin
               clk_en_d = clk_en_q | lat_sel;
               cnt_d    = CNT_W'(CLK_WAIT);
               state_d  = CLK_SETTLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CLK_SETTLE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               on_d    = on_q | lat_sel;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         CLK_OFF: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               rst_d   = rst_q | lat_sel;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs and datapath. A reset aborts any command in flight
   // and returns every domain to held-in-reset with its clock gated.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         dom_q    <= '0;
         rst_q    <= '1;
         clk_en_q <= '0;
         on_q     <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         dom_q    <= dom_d;
         rst_q    <= rst_d;
         clk_en_q <= clk_en_d;
         on_q     <= on_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Handshake and status outputs decoded straight from the state.
   always_comb begin
      req_ready_o = (state_q == IDLE);
      busy_o      = (state_q != IDLE);
   end

   assign done_o       = done_q;
   assign done_err_o   = err_q;
   assign dom_rst_o    = rst_q;
   assign dom_clk_en_o = clk_en_q;
   assign dom_on_o     = on_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Directed scenarios followed by randomized commands, all compared every
// cycle against a timeline model: on accept the model records the command
// kind and the edge count at which each milestone falls, then applies the
// milestone effects as the edge count reaches them. NUM_DOM is 5 so the
// 3-bit index can address out-of-range domains 5..7.
// ---------------------------------------------------------------------------
module tb_rst_seq_ctrl;

   localparam int NUM_DOM  = 5;
   localparam int DOM_W    = 3;
   localparam int RST_WAIT = 6;
   localparam int CLK_WAIT = 2;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               req_valid_i;
   logic               req_ready_o;
   logic [DOM_W-1:0]   req_dom_i;
   logic               req_on_i;
   logic               done_o;
   logic               done_err_o;
   logic [NUM_DOM-1:0] dom_rst_o;
   logic [NUM_DOM-1:0] dom_clk_en_o;
   logic [NUM_DOM-1:0] dom_on_o;
   logic               busy_o;

   rst_seq_ctrl #(
      .NUM_DOM  (NUM_DOM),
      .RST_WAIT (RST_WAIT),
      .CLK_WAIT (CLK_WAIT)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_dom_i    (req_dom_i),
      .req_on_i     (req_on_i),
      .done_o       (done_o),
      .done_err_o   (done_err_o),
      .dom_rst_o    (dom_rst_o),
      .dom_clk_en_o (dom_clk_en_o),
      .dom_on_o     (dom_on_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model state: expected outputs after the most recent edge.
   logic [NUM_DOM-1:0] m_rst;
   logic [NUM_DOM-1:0] m_en;
   logic [NUM_DOM-1:0] m_on;
   logic               m_done;
   logic               m_err;
   logic               m_active;
   int                 m_age;
   int                 m_fin;
   int                 m_dom;
   logic               m_up;
   logic               m_down;

   int checkCount;
   int errorCount;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the timeline model by one edge using the inputs seen at it.
   task automatic modelEdge();
      if (rst_i) begin
         m_rst    = '1;
         m_en     = '0;
         m_on     = '0;
         m_done   = 1'b0;
         m_err    = 1'b0;
         m_active = 1'b0;
      end else if (!m_active) begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (req_valid_i) begin
            m_active = 1'b1;
            m_age    = 0;
            m_dom    = int'(req_dom_i);
            m_up     = 1'b0;
            m_down   = 1'b0;
            if (m_dom >= NUM_DOM) begin
               m_fin  = 0;
               m_done = 1'b1;
               m_err  = 1'b1;
            end else if (req_on_i == m_on[m_dom]) begin
               m_fin  = 0;
               m_done = 1'b1;
            end else if (req_on_i) begin
               m_up         = 1'b1;
               m_fin        = RST_WAIT + CLK_WAIT;
               m_rst[m_dom] = 1'b0;
            end else begin
               m_down       = 1'b1;
               m_fin        = CLK_WAIT;
               m_en[m_dom]  = 1'b0;
               m_on[m_dom]  = 1'b0;
            end
         end
      end else begin
         m_age++;
         m_done = 1'b0;
         m_err  = 1'b0;
         if (m_age == m_fin + 1) begin
            m_active = 1'b0;
         end else begin
            if (m_up && m_age == RST_WAIT) m_en[m_dom] = 1'b1;
            if (m_age == m_fin) begin
               m_done = 1'b1;
               if (m_up) m_on[m_dom] = 1'b1;
               if (m_down) m_rst[m_dom] = 1'b1;
            end
         end
      end
   endtask

   task automatic checkAll();
      checkOutput("dom_rst",    32'(dom_rst_o),    32'(m_rst));
      checkOutput("dom_clk_en", 32'(dom_clk_en_o), 32'(m_en));
      checkOutput("dom_on",     32'(dom_on_o),     32'(m_on));
      checkOutput("done",       32'(done_o),       32'(m_done));
      checkOutput("done_err",   32'(done_err_o),   32'(m_err));
      checkOutput("ready",      32'(req_ready_o),  32'(!m_active));
      checkOutput("busy",       32'(busy_o),       32'(m_active));
      checkOutput("inv_en_rst", 32'(dom_clk_en_o & dom_rst_o), 32'(0));
      checkOutput("inv_on_en",  32'(dom_on_o & ~dom_clk_en_o), 32'(0));
   endtask

   task automatic step();
      @(posedge clk_i);
      modelEdge();
      @(negedge clk_i);
      checkAll();
   endtask

   task automatic applyStimulus(input logic rst, input logic valid, input int dom,
                                input logic on, input int cycles);
      rst_i       = rst;
      req_valid_i = valid;
      req_dom_i   = DOM_W'(dom);
      req_on_i    = on;
      repeat (cycles) step();
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      m_rst = '1; m_en = '0; m_on = '0;
      m_done = 1'b0; m_err = 1'b0; m_active = 1'b0;
      m_age = 0; m_fin = 0; m_dom = 0; m_up = 1'b0; m_down = 1'b0;
      rst_i = 1'b1; req_valid_i = 1'b0; req_dom_i = '0; req_on_i = 1'b0;

      // Reset for three cycles.
      applyStimulus(1, 0, 0, 0, 3);

      // Power-up domain 2, then power it down.
      applyStimulus(0, 1, 2, 1, 1);
      applyStimulus(0, 0, 0, 0, 10);
      applyStimulus(0, 1, 2, 0, 1);
      applyStimulus(0, 0, 0, 0, 4);

      // Up again, then a redundant up (no-op) and out-of-range indices.
      applyStimulus(0, 1, 2, 1, 1);
      applyStimulus(0, 0, 0, 0, 10);
      applyStimulus(0, 1, 2, 1, 1);
      applyStimulus(0, 0, 0, 0, 2);
      applyStimulus(0, 1, 5, 1, 1);
      applyStimulus(0, 0, 0, 0, 2);
      applyStimulus(0, 1, 7, 0, 1);
      applyStimulus(0, 0, 0, 0, 2);

      // Reset in the middle of powering up domain 1.
      applyStimulus(0, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 2);
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 3);

      // Back-to-back with valid held: up(0) then up(1).
      applyStimulus(0, 1, 0, 1, 10);
      applyStimulus(0, 1, 1, 1, 10);
      applyStimulus(0, 0, 0, 0, 2);
      checkOutput("b2b_dom_on", 32'(dom_on_o), 32'(5'b00011));

      // Randomized commands with occasional resets.
      for (int n = 0; n < 2500; n++) begin
         applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                       1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)),
                       1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
